// File: rtl/nios_upc_lcd_ctrl.sv
// nios_upc_lcd_ctrl
// Avalon-MM slave that turns single read/write transfers into HD44780-style
// LCD bus cycles (setup, E strobe, hold), in 8-bit or 4-bit (nibble) mode.
//
// Ports
//   clk, reset_n      system clock, asynchronous active-low reset
//   address[1:0]      bit1 -> LCD RS, bit0 -> LCD RW
//   read, write       Avalon requests, held by the master while waitrequest=1
//   writedata[7:0]    byte sent to the LCD
//   readdata[7:0]     byte read back from the LCD (registered)
//   waitrequest       stall, low only in the single DONE cycle of a transfer
//   LCD_E/RS/RW       registered LCD control lines
//   LCD_data[7:0]     bidirectional LCD bus, Z unless the block is writing
module nios_upc_lcd_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int SETUP_CYC  = 2,
  parameter int E_HIGH_CYC = 12,
  parameter int HOLD_CYC   = 11
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] address,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_data
);

  localparam int MAX_SE  = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
  localparam int MAX_CYC = (MAX_SE > HOLD_CYC) ? MAX_SE : HOLD_CYC;
  localparam int CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

  // Counters hold "cycles remaining minus one", so a phase of N cycles
  // loads N-1 on entry and leaves when the count reaches zero.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EHIGH_LD = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_EHIGH = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             nib_q, nib_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic             rw_q, rw_d;
  logic [7:0]       cap_q, cap_d;
  logic [7:0]       readdata_q, readdata_d;
  logic             lcd_e_q, lcd_e_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic             lcd_rw_q, lcd_rw_d;
  logic             active_d;
  logic             drive_en;
  logic [7:0]       drive_val;

  always_comb begin
    state_d    = state_q;
    nib_d      = nib_q;
    cnt_d      = cnt_q;
    byte_d     = byte_q;
    rw_d       = rw_q;
    cap_d      = cap_q;
    readdata_d = readdata_q;
    lcd_rs_d   = lcd_rs_q;

    case (state_q)
      S_IDLE: begin
        if (read | write) begin
          state_d  = S_SETUP;
          cnt_d    = SETUP_LD;
          nib_d    = 1'b0;
          byte_d   = writedata;
          lcd_rs_d = address[1];
          // A simultaneous read+write is resolved as a write.
          rw_d     = (read & write) ? 1'b0 : address[0];
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_EHIGH;
          cnt_d   = EHIGH_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_EHIGH: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
          // Sample on the last E-high cycle, just before E falls.
          if (rw_q) begin
            if (DATA_BITS == 4) begin
              if (nib_q) cap_d[3:0] = LCD_data[7:4];
              else       cap_d[7:4] = LCD_data[7:4];
            end else begin
              cap_d = LCD_data;
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          if ((DATA_BITS == 4) && !nib_q) begin
            nib_d   = 1'b1;
            state_d = S_SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            state_d = S_DONE;
            cnt_d   = '0;
            if (rw_q) readdata_d = cap_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Control lines are registered from the next state so they line up
    // exactly with the state they belong to.
    active_d = (state_d == S_SETUP) || (state_d == S_EHIGH) || (state_d == S_HOLD);
    lcd_e_d  = (state_d == S_EHIGH);
    lcd_rw_d = active_d ? rw_d : 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      nib_q      <= 1'b0;
      cnt_q      <= '0;
      byte_q     <= 8'h00;
      rw_q       <= 1'b1;
      cap_q      <= 8'h00;
      readdata_q <= 8'h00;
      lcd_e_q    <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_rw_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      nib_q      <= nib_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      rw_q       <= rw_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
      lcd_e_q    <= lcd_e_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_rw_q   <= lcd_rw_d;
    end
  end

  assign drive_en = !rw_q &&
                    ((state_q == S_SETUP) || (state_q == S_EHIGH) || (state_q == S_HOLD));

  // Nibble mode puts the active nibble on [7:4] and holds [3:0] low.
  always_comb begin
    if (DATA_BITS == 4) drive_val = {(nib_q ? byte_q[3:0] : byte_q[7:4]), 4'h0};
    else                drive_val = byte_q;
  end

  assign LCD_data    = drive_en ? drive_val : 8'hzz;
  assign waitrequest = (read | write) & (state_q != S_DONE);
  assign readdata    = readdata_q;
  assign LCD_E       = lcd_e_q;
  assign LCD_RS      = lcd_rs_q;
  assign LCD_RW      = lcd_rw_q;

endmodule
